// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the int_ctrl interrupt controller: register offsets,
// FSM state encoding and CLAIM read layout.
package int_ctrl_pkg;

  localparam logic [1:0] INT_MASK  = 2'd0;
  localparam logic [1:0] INT_PEND  = 2'd1;
  localparam logic [1:0] INT_MODE  = 2'd2;
  localparam logic [1:0] INT_CLAIM = 2'd3;

  localparam int unsigned CLAIM_VALID_BIT = 31;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StService
  } state_e;

endpackage

// File: rtl/int_ctrl_src.sv
// Per-source front end: optional 2-flop synchronizer (INT_CTRL_SYNC_EN), source
// register, rising-edge detection and the pending bit for edge or level mode.
module int_ctrl_src (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  input  logic clr,
  output logic pend
);

  logic src_in;
  logic src_q;
  logic pend_q;

`ifdef INT_CTRL_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], src};
    end
  end

  assign src_in = sync_q[1];
`else
  assign src_in = src;
`endif

  // Level mode mirrors src_q; edge mode lets a new edge win over a clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      src_q <= src_in;
      if (!mode) begin
        pend_q <= src_in;
      end else if (src_in && !src_q) begin
        pend_q <= 1'b1;
      end else if (clr) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller top: MASK/PEND/MODE/CLAIM registers, priority
// encoder and claim/complete FSM. INT_CTRL_SYNC_EN adds source synchronizers.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 6,
  parameter int unsigned ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             sel,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic             RE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             IRQ,
  output logic [ID_W-1:0]  irq_id
);

  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  best;
  logic [ID_W-1:0]  cur_id_q;
  state_e           state_q;
  logic             wr_en;
  logic             rd_en;
  logic             claim;
  logic             eoi;
  logic             w1c;
  logic             unused_din;

  assign unused_din = ^Din;

  // A write in the same cycle as a read suppresses the read side effect.
  assign wr_en = sel & WE;
  assign rd_en = sel & RE & ~WE;
  assign claim = rd_en & (Addr == INT_CLAIM) & (state_q == StAssert);
  assign eoi   = wr_en & (Addr == INT_CLAIM) & (state_q == StService) &
                 (Din[ID_W-1:0] == cur_id_q);
  assign w1c   = wr_en & (Addr == INT_PEND);

  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      clr[i] = (w1c & Din[i]) | (claim & (cur_id_q == ID_W'(i)));
    end
  end

  for (genvar g = 0; g < int'(N_SRC); g++) begin : g_src
    int_ctrl_src u_src (
      .clk  (clk),
      .reset(reset),
      .src  (src[g]),
      .mode (mode_q[g]),
      .clr  (clr[g]),
      .pend (pend[g])
    );
  end

  assign active = pend & mask_q;

  always_comb begin
    best = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        best = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q <= '0;
      mode_q <= '0;
    end else if (wr_en) begin
      if (Addr == INT_MASK) mask_q <= Din[N_SRC-1:0];
      if (Addr == INT_MODE) mode_q <= Din[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cur_id_q <= '0;
      IRQ      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|active) begin
            state_q  <= StAssert;
            cur_id_q <= best;
            IRQ      <= 1'b1;
          end
        end
        StAssert: begin
          if (claim) begin
            state_q <= StService;
            IRQ     <= 1'b0;
          end else if (~|active) begin
            state_q <= StIdle;
            IRQ     <= 1'b0;
          end else begin
            cur_id_q <= best;
          end
        end
        StService: begin
          if (eoi) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          IRQ     <= 1'b0;
        end
      endcase
    end
  end

  assign irq_id = cur_id_q;

  always_comb begin
    Dout = '0;
    case (Addr)
      INT_MASK: Dout[N_SRC-1:0] = mask_q;
      INT_PEND: Dout[N_SRC-1:0] = pend;
      INT_MODE: Dout[N_SRC-1:0] = mode_q;
      INT_CLAIM: begin
        if (state_q == StAssert) begin
          Dout[CLAIM_VALID_BIT] = 1'b1;
          Dout[ID_W-1:0]        = cur_id_q;
        end
      end
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized bus/source
// traffic compared against a behavioural model. Honours INT_CTRL_SYNC_EN.
module tb_int_ctrl;

  localparam int N  = 6;
  localparam int IW = 3;
`ifdef INT_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src;
  logic          sel;
  logic [1:0]    Addr;
  logic          WE;
  logic          RE;
  logic [31:0]   Din;
  logic [31:0]   Dout;
  logic          IRQ;
  logic [IW-1:0] irq_id;

  int checks = 0;
  int errors = 0;

  int_ctrl #(.N_SRC(N)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .sel   (sel),
    .Addr  (Addr),
    .WE    (WE),
    .RE    (RE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  // Reference model: pending vector, request/service flags and presented id.
  logic [N-1:0]  m_mask, m_mode, m_pend, m_srcq, m_s1, m_s2;
  bit            m_irq, m_serv;
  logic [IW-1:0] m_id;

  function automatic logic [31:0] model_dout(input logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 2'd0) r = 32'(m_mask);
    if (a == 2'd1) r = 32'(m_pend);
    if (a == 2'd2) r = 32'(m_mode);
    if (a == 2'd3 && m_irq) r = 32'h8000_0000 | 32'(m_id);
    return r;
  endfunction

  task automatic model_next();
    logic [N-1:0] sin, act, np;
    int  b;
    bit  claim, eoi, w1c, wr;
    if (!reset) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_srcq = '0; m_s1 = '0; m_s2 = '0;
      m_irq = 0; m_serv = 0; m_id = '0;
      return;
    end
`ifdef INT_CTRL_SYNC_EN
    sin = m_s2;
`else
    sin = src;
`endif
    act = m_pend & m_mask;
    b = -1;
    for (int i = N - 1; i >= 0; i--) if (act[i]) b = i;
    wr    = sel && WE;
    claim = sel && RE && !WE && Addr == 2'd3 && m_irq;
    eoi   = wr && Addr == 2'd3 && m_serv && Din[IW-1:0] == m_id;
    w1c   = wr && Addr == 2'd1;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i])
        np[i] = (sin[i] && !m_srcq[i]) ||
                (m_pend[i] && !(w1c && Din[i]) && !(claim && int'(m_id) == i));
      else
        np[i] = sin[i];
    end
    if (m_irq) begin
      if (claim) begin m_irq = 0; m_serv = 1; end
      else if (act == 0) m_irq = 0;
      else m_id = IW'(b);
    end else if (m_serv) begin
      if (eoi) m_serv = 0;
    end else if (act != 0) begin
      m_irq = 1; m_id = IW'(b);
    end
    if (wr && Addr == 2'd0) m_mask = Din[N-1:0];
    if (wr && Addr == 2'd2) m_mode = Din[N-1:0];
    m_pend = np;
    m_srcq = sin;
    m_s2   = m_s1;
    m_s1   = src;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    model_next();
    @(posedge clk);
    #1;
    check("irq_model", 32'(IRQ), 32'(m_irq));
    check("irq_id_model", 32'(irq_id), 32'(m_id));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1; WE = 1; Addr = a; Din = d;
    cyc();
    sel = 0; WE = 0; Din = '0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    sel = 1; RE = 1; Addr = a;
    #1;
    check(tag, Dout, exp);
    check("rd_model", Dout, model_dout(a));
    cyc();
    sel = 0; RE = 0;
  endtask

  initial begin
    reset = 0; src = '0; sel = 0; Addr = '0; WE = 0; RE = 0; Din = '0;
    cyc();
    cyc();
    reset = 1;
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    rd_chk(2'd0, 32'd0, "rst_mask");
    rd_chk(2'd1, 32'd0, "rst_pend");
    rd_chk(2'd2, 32'd0, "rst_mode");
    rd_chk(2'd3, 32'd0, "rst_claim");

    // Source-to-IRQ latency.
    wr(2'd0, 32'h3F);
    wr(2'd2, 32'h3F);
    src = 6'h02;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      if (k == 1) src = '0;
      check("latency", 32'(IRQ), (k == LAT) ? 32'd1 : 32'd0);
    end
    rd_chk(2'd3, 32'h8000_0001, "lat_claim");
    wr(2'd3, 32'd1);
    cyc();

`ifndef INT_CTRL_SYNC_EN
    // Edge pulse on src[0], claim, pending cleared.
    wr(2'd2, 32'h01);
    src = 6'h01;
    cyc();
    src = '0;
    rd_chk(2'd1, 32'h1, "t1_pend");
    check("t1_irq", 32'(IRQ), 32'd1);
    rd_chk(2'd3, 32'h8000_0000, "t1_claim");
    check("t1_irq_low", 32'(IRQ), 32'd0);
    rd_chk(2'd1, 32'h0, "t1_pend_clr");
    wr(2'd3, 32'd0);

    // Level source re-asserts after EOI until it drops.
    wr(2'd2, 32'h00);
    src = 6'h04;
    cyc();
    cyc();
    check("t2_irq", 32'(IRQ), 32'd1);
    check("t2_id", 32'(irq_id), 32'd2);
    rd_chk(2'd3, 32'h8000_0002, "t2_claim");
    wr(2'd3, 32'd2);
    cyc();
    check("t2_reassert", 32'(IRQ), 32'd1);
    rd_chk(2'd3, 32'h8000_0002, "t2_claim2");
    src = '0;
    cyc();
    wr(2'd3, 32'd2);
    cyc();
    cyc();
    check("t2_idle", 32'(IRQ), 32'd0);

    // Higher priority preempts before claim; lower one returns after EOI.
    wr(2'd2, 32'h3F);
    src = 6'h10;
    cyc();
    src = '0;
    cyc();
    check("t3_id4", 32'(irq_id), 32'd4);
    src = 6'h02;
    cyc();
    src = '0;
    cyc();
    check("t3_id1", 32'(irq_id), 32'd1);
    rd_chk(2'd3, 32'h8000_0001, "t3_claim");
    wr(2'd3, 32'd1);
    cyc();
    check("t3_irq4", 32'(IRQ), 32'd1);
    check("t3_id4b", 32'(irq_id), 32'd4);
    rd_chk(2'd3, 32'h8000_0004, "t3_claim4");
    wr(2'd3, 32'd4);

    // Edge and W1C in the same cycle: the edge wins.
    src = 6'h01;
    sel = 1; WE = 1; Addr = 2'd1; Din = 32'h1;
    cyc();
    sel = 0; WE = 0; Din = '0;
    rd_chk(2'd1, 32'h1, "t4_pend");
    wr(2'd1, 32'h1);
    cyc();
    check("t4_withdrawn", 32'(IRQ), 32'd0);
    src = '0;
    cyc();

    // Mismatched EOI ignored, matching EOI completes, then reset mid-ASSERT.
    src = 6'h08;
    cyc();
    src = '0;
    cyc();
    rd_chk(2'd3, 32'h8000_0003, "t5_claim");
    wr(2'd3, 32'd5);
    rd_chk(2'd3, 32'h0, "t5_claim_svc");
    src = 6'h08;
    cyc();
    src = '0;
    cyc();
    cyc();
    check("t5_stay", 32'(IRQ), 32'd0);
    wr(2'd3, 32'd3);
    cyc();
    check("t5_reassert", 32'(IRQ), 32'd1);
    reset = 0;
    cyc();
    check("t5_rst_irq", 32'(IRQ), 32'd0);
    rd_chk(2'd0, 32'h0, "t5_rst_mask");
    reset = 1;
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      int op;
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) < 3) src = N'($urandom);
      op = $urandom_range(0, 9);
      sel = 0; WE = 0; RE = 0; Din = $urandom;
      Addr = 2'($urandom_range(0, 3));
      case (op)
        0: begin sel = 1; WE = 1; Addr = 2'd0; end
        1: begin sel = 1; WE = 1; Addr = 2'd2; end
        2: begin sel = 1; WE = 1; Addr = 2'd1; end
        3, 4: begin sel = 1; RE = 1; Addr = 2'd3; end
        5, 6: begin
          sel = 1; WE = 1; Addr = 2'd3;
          if ($urandom_range(0, 3) != 0) Din = 32'(m_id);
        end
        7: begin sel = 1; RE = 1; end
        default: ;
      endcase
      #1;
      check("rnd_dout", Dout, model_dout(Addr));
      cyc();
      sel = 0; WE = 0; RE = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
